// File: rtl/rx_pause_detect.sv
`default_nettype none
// ============================================================================
// Module   : rx_pause_detect
// Brief    : Parses frames from the MAC receive byte interface, recognises
//            802.3x PAUSE frames (DA 01-80-C2-00-00-01, EtherType 88-08,
//            opcode 00-01, length >= 64) and runs the pause timer that
//            holds off the local transmitter.
//            Optional macro PAUSE_UNICAST_DA_EN: also accept PAUSE frames
//            addressed to STATION_ADDR.
// Revision : 1.0 - initial release
// ============================================================================
module rx_pause_detect #(
    parameter int          QUANTUM_CYCLES = 64,
    parameter logic [47:0] STATION_ADDR   = 48'h02_00_00_00_00_01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_mac_data,
    input  logic        rx_mac_valid,
    output logic        pause_active,
    output logic [15:0] pause_quanta,
    output logic [47:0] pause_src_addr,
    output logic        pause_frame_strobe,
    output logic [15:0] pause_frame_cnt
);

    // Parser states
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_hdr  = 2'd1;
    localparam logic [1:0] c_st_pad  = 2'd2;
    localparam logic [1:0] c_st_drop = 2'd3;

    // Sub-quantum counter sizing; at least one bit even for tiny quanta
    localparam int                 c_sub_w   = (QUANTUM_CYCLES > 2) ? $clog2(QUANTUM_CYCLES) : 1;
    localparam logic [c_sub_w-1:0] c_sub_max = c_sub_w'(QUANTUM_CYCLES - 1);

    localparam logic [47:0] c_pause_da  = 48'h01_80_C2_00_00_01;
    localparam logic [6:0]  c_min_len   = 7'd64;
    localparam logic [6:0]  c_last_hdr  = 7'd17;
    localparam logic [15:0] c_cnt_max   = 16'hFFFF;

    // Byte idx (0..5) of a 48-bit address, most significant byte first
    function automatic logic [7:0] addr_byte(input logic [47:0] addr, input logic [6:0] idx);
        logic [7:0] b;
        case (idx)
            7'd0:    b = addr[47:40];
            7'd1:    b = addr[39:32];
            7'd2:    b = addr[31:24];
            7'd3:    b = addr[23:16];
            7'd4:    b = addr[15:8];
            7'd5:    b = addr[7:0];
            default: b = 8'h00;
        endcase
        addr_byte = b;
    endfunction

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [6:0]         r_byte_idx;
    logic [6:0]         w_idx;
    logic               w_hdr_byte;
    logic               r_mc_ok;
    logic               w_mc_match;
    logic               w_uc_match;
    logic               w_da_ok;
    logic               w_hdr_ok;
    logic               w_frame_end;
    logic               w_accept;
    logic [47:0]        r_sa_shadow;
    logic [15:0]        r_pt_shadow;
    logic [15:0]        r_quanta_left;
    logic [c_sub_w-1:0] r_sub_cnt;
    logic [15:0]        r_pause_quanta;
    logic [47:0]        r_pause_src_addr;
    logic               r_strobe;
    logic [15:0]        r_frame_cnt;

`ifdef PAUSE_UNICAST_DA_EN
    logic               r_uc_ok;
`else
    logic               w_unused_station;
    assign w_unused_station = ^STATION_ADDR;
`endif

    // Index of the byte currently on the bus; byte 0 arrives while still in IDLE
    assign w_idx      = (r_state == c_st_idle) ? 7'd0 : r_byte_idx;
    assign w_hdr_byte = rx_mac_valid && ((r_state == c_st_idle) || (r_state == c_st_hdr));

    // On-the-fly header comparison of the current byte
    always_comb begin
        w_mc_match = (rx_mac_data == addr_byte(c_pause_da, w_idx)) &&
                     ((w_idx == 7'd0) || r_mc_ok);
`ifdef PAUSE_UNICAST_DA_EN
        w_uc_match = (rx_mac_data == addr_byte(STATION_ADDR, w_idx)) &&
                     ((w_idx == 7'd0) || r_uc_ok);
`else
        w_uc_match = 1'b0;
`endif
        w_da_ok = w_mc_match | w_uc_match;
        case (w_idx)
            7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5: w_hdr_ok = w_da_ok;
            7'd12:   w_hdr_ok = (rx_mac_data == 8'h88);
            7'd13:   w_hdr_ok = (rx_mac_data == 8'h08);
            7'd14:   w_hdr_ok = (rx_mac_data == 8'h00);
            7'd15:   w_hdr_ok = (rx_mac_data == 8'h01);
            default: w_hdr_ok = 1'b1;
        endcase
    end

    // Parser state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Parser next-state logic; every frame end returns to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (rx_mac_valid) begin
                    w_next_state = w_hdr_ok ? c_st_hdr : c_st_drop;
                end
            end
            c_st_hdr: begin
                if (!rx_mac_valid) begin
                    w_next_state = c_st_idle;
                end else if (!w_hdr_ok) begin
                    w_next_state = c_st_drop;
                end else if (w_idx == c_last_hdr) begin
                    w_next_state = c_st_pad;
                end
            end
            c_st_pad: begin
                if (!rx_mac_valid) begin
                    w_next_state = c_st_idle;
                end
            end
            c_st_drop: begin
                if (!rx_mac_valid) begin
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // Parser outputs: frame end and the acceptance decision
    always_comb begin
        w_frame_end = (r_state != c_st_idle) && !rx_mac_valid;
        w_accept    = w_frame_end && (r_state == c_st_pad) && (r_byte_idx >= c_min_len);
    end

    // Byte counter, DA match flags and shadow capture of SA / pause_time
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_idx  <= 7'd0;
            r_mc_ok     <= 1'b0;
`ifdef PAUSE_UNICAST_DA_EN
            r_uc_ok     <= 1'b0;
`endif
            r_sa_shadow <= 48'd0;
            r_pt_shadow <= 16'd0;
        end else begin
            if (!rx_mac_valid) begin
                r_byte_idx <= 7'd0;
            end else if (r_state == c_st_idle) begin
                r_byte_idx <= 7'd1;
            end else if (r_byte_idx != c_min_len) begin
                r_byte_idx <= r_byte_idx + 7'd1;
            end

            if (w_hdr_byte && (w_idx <= 7'd5)) begin
                r_mc_ok <= w_mc_match;
`ifdef PAUSE_UNICAST_DA_EN
                r_uc_ok <= w_uc_match;
`endif
            end

            if (w_hdr_byte && (w_idx >= 7'd6) && (w_idx <= 7'd11)) begin
                r_sa_shadow <= {r_sa_shadow[39:0], rx_mac_data};
            end

            if (w_hdr_byte && ((w_idx == 7'd16) || (w_idx == 7'd17))) begin
                r_pt_shadow <= {r_pt_shadow[7:0], rx_mac_data};
            end
        end
    end

    // Publish results of an accepted frame; rejected shadows never get here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pause_quanta   <= 16'd0;
            r_pause_src_addr <= 48'd0;
            r_strobe         <= 1'b0;
            r_frame_cnt      <= 16'd0;
        end else begin
            r_strobe <= w_accept;
            if (w_accept) begin
                r_pause_quanta   <= r_pt_shadow;
                r_pause_src_addr <= r_sa_shadow;
                if (r_frame_cnt != c_cnt_max) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    // Pause timer; a fresh frame reloads and wins over the running decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_quanta_left <= 16'd0;
            r_sub_cnt     <= '0;
        end else if (w_accept) begin
            r_quanta_left <= r_pt_shadow;
            r_sub_cnt     <= c_sub_max;
        end else if (r_quanta_left != 16'd0) begin
            if (r_sub_cnt == '0) begin
                r_sub_cnt     <= c_sub_max;
                r_quanta_left <= r_quanta_left - 16'd1;
            end else begin
                r_sub_cnt <= r_sub_cnt - 1'b1;
            end
        end
    end

    assign pause_active       = (r_quanta_left != 16'd0);
    assign pause_quanta       = r_pause_quanta;
    assign pause_src_addr     = r_pause_src_addr;
    assign pause_frame_strobe = r_strobe;
    assign pause_frame_cnt    = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rx_pause_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_pause_detect
// Brief    : Directed self-checking bench for rx_pause_detect.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_pause_detect;

    localparam logic [47:0] c_mc_da   = 48'h01_80_C2_00_00_01;
    localparam logic [47:0] c_station = 48'h02_00_00_00_00_01;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_mac_data;
    logic        rx_mac_valid;
    logic        pause_active;
    logic [15:0] pause_quanta;
    logic [47:0] pause_src_addr;
    logic        pause_frame_strobe;
    logic [15:0] pause_frame_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  fbuf [0:127];
    logic [15:0] exp_cnt    = 16'd0;
    logic [15:0] exp_quanta = 16'd0;
    logic [47:0] exp_sa     = 48'd0;

    rx_pause_detect #(
        .QUANTUM_CYCLES (64),
        .STATION_ADDR   (c_station)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .rx_mac_data        (rx_mac_data),
        .rx_mac_valid       (rx_mac_valid),
        .pause_active       (pause_active),
        .pause_quanta       (pause_quanta),
        .pause_src_addr     (pause_src_addr),
        .pause_frame_strobe (pause_frame_strobe),
        .pause_frame_cnt    (pause_frame_cnt)
    );

    always #5 clk = ~clk;

    // Fill the frame buffer: header fields then arbitrary padding bytes
    task automatic build_frame(input logic [47:0] da, input logic [47:0] sa,
                               input logic [15:0] et, input logic [15:0] op,
                               input logic [15:0] pt);
        for (int i = 0; i < 128; i++) fbuf[i] = 8'(i * 7 + 3);
        for (int i = 0; i < 6; i++) begin
            fbuf[i]     = da[47 - 8*i -: 8];
            fbuf[6 + i] = sa[47 - 8*i -: 8];
        end
        fbuf[12] = et[15:8]; fbuf[13] = et[7:0];
        fbuf[14] = op[15:8]; fbuf[15] = op[7:0];
        fbuf[16] = pt[15:8]; fbuf[17] = pt[7:0];
    endtask

    // Drive n bytes; optionally drop valid afterwards (that cycle is E)
    task automatic drive(input int n, input bit terminate);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_mac_data  = fbuf[i];
            rx_mac_valid = 1'b1;
        end
        if (terminate) begin
            @(negedge clk);
            rx_mac_valid = 1'b0;
            rx_mac_data  = 8'h00;
        end
    endtask

    task automatic send_frame(input logic [47:0] da, input logic [47:0] sa,
                              input logic [15:0] et, input logic [15:0] op,
                              input logic [15:0] pt, input int len);
        build_frame(da, sa, et, op, pt);
        drive(len, 1'b1);
    endtask

    // Called in cycle E: checks strobe at E+1 and the active-window length
    task automatic measure_active(input int expected, input string name);
        int n;
        int extra;
        n     = 0;
        extra = 0;
        @(negedge clk);
        checks++;
        if (pause_frame_strobe !== 1'b1) begin
            errors++;
            $display("FAIL %s strobe@E+1: got %b expected 1", name, pause_frame_strobe);
        end
        while (pause_active === 1'b1 && n < 20000) begin
            n++;
            @(negedge clk);
            if (pause_frame_strobe !== 1'b0) extra++;
        end
        checks++;
        if (n != expected) begin
            errors++;
            $display("FAIL %s active_cycles: got %0d expected %0d", name, n, expected);
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL %s extra_strobes: got %0d expected 0", name, extra);
        end
    endtask

    task automatic check_outputs(input string name);
        checks++;
        if (pause_frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s cnt: got %0d expected %0d", name, pause_frame_cnt, exp_cnt);
        end
        checks++;
        if (pause_quanta !== exp_quanta) begin
            errors++;
            $display("FAIL %s quanta: got %0h expected %0h", name, pause_quanta, exp_quanta);
        end
        checks++;
        if (pause_src_addr !== exp_sa) begin
            errors++;
            $display("FAIL %s sa: got %h expected %h", name, pause_src_addr, exp_sa);
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        rx_mac_valid = 1'b0;
        rx_mac_data  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pause_active !== 1'b0 || pause_frame_strobe !== 1'b0) begin
            errors++;
            $display("FAIL reset active/strobe: got %b/%b expected 0/0",
                     pause_active, pause_frame_strobe);
        end
        check_outputs("reset");
    endtask

    task automatic test_basic();
        send_frame(c_mc_da, 48'hA1_B2_C3_D4_E5_F6, 16'h8808, 16'h0001, 16'h0003, 64);
        checks++;
        if (pause_frame_strobe !== 1'b0) begin
            errors++;
            $display("FAIL basic strobe@E: got %b expected 0", pause_frame_strobe);
        end
        exp_cnt = 16'd1; exp_quanta = 16'd3; exp_sa = 48'hA1_B2_C3_D4_E5_F6;
        measure_active(192, "basic");
        check_outputs("basic");
    endtask

    task automatic reject_one(input string name, input logic [47:0] da,
                              input logic [15:0] et, input logic [15:0] op, input int len);
        int seen;
        seen = 0;
        send_frame(da, 48'hDE_AD_BE_EF_00_11, et, op, 16'h0009, len);
        repeat (6) begin
            @(negedge clk);
            if (pause_frame_strobe !== 1'b0 || pause_active !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s strobe_or_active: got %0d cycles expected 0", name, seen);
        end
        check_outputs(name);
    endtask

    task automatic test_reject();
        reject_one("runt60",  c_mc_da, 16'h8808, 16'h0001, 60);
        reject_one("runt63",  c_mc_da, 16'h8808, 16'h0001, 63);
        reject_one("etype",   c_mc_da, 16'h0800, 16'h0001, 64);
        reject_one("opcode",  c_mc_da, 16'h8808, 16'h0002, 64);
        reject_one("da_miss", 48'h01_80_C2_00_00_02, 16'h8808, 16'h0001, 64);
    endtask

    task automatic test_zero_clear();
        send_frame(c_mc_da, 48'h11_22_33_44_55_66, 16'h8808, 16'h0001, 16'd100, 64);
        repeat (1000) @(negedge clk);
        checks++;
        if (pause_active !== 1'b1) begin
            errors++;
            $display("FAIL zero_clear mid_pause: got %b expected 1", pause_active);
        end
        send_frame(c_mc_da, 48'h66_55_44_33_22_11, 16'h8808, 16'h0001, 16'd0, 64);
        checks++;
        if (pause_active !== 1'b1) begin
            errors++;
            $display("FAIL zero_clear active@E: got %b expected 1", pause_active);
        end
        exp_cnt = exp_cnt + 16'd2; exp_quanta = 16'd0; exp_sa = 48'h66_55_44_33_22_11;
        measure_active(0, "zero_clear");
        check_outputs("zero_clear");
    endtask

    task automatic test_override();
        send_frame(c_mc_da, 48'h0A_0B_0C_0D_0E_0F, 16'h8808, 16'h0001, 16'd2, 64);
        repeat (50) @(negedge clk);
        send_frame(c_mc_da, 48'h1A_1B_1C_1D_1E_1F, 16'h8808, 16'h0001, 16'd5, 64);
        exp_cnt = exp_cnt + 16'd2; exp_quanta = 16'd5; exp_sa = 48'h1A_1B_1C_1D_1E_1F;
        measure_active(320, "override");
        check_outputs("override");
    endtask

    task automatic test_back_to_back();
        send_frame(c_mc_da, 48'hAA_00_00_00_00_01, 16'h8808, 16'h0001, 16'd1, 64);
        send_frame(c_mc_da, 48'hBB_00_00_00_00_02, 16'h8808, 16'h0001, 16'd4, 70);
        exp_cnt = exp_cnt + 16'd2; exp_quanta = 16'd4; exp_sa = 48'hBB_00_00_00_00_02;
        measure_active(256, "b2b");
        check_outputs("b2b");
    endtask

    task automatic test_reset_mid();
        build_frame(c_mc_da, 48'hCC_CC_CC_CC_CC_CC, 16'h8808, 16'h0001, 16'd7);
        drive(10, 1'b0);
        @(negedge clk);
        reset        = 1'b1;
        rx_mac_valid = 1'b0;
        #1;
        exp_cnt = 16'd0; exp_quanta = 16'd0; exp_sa = 48'd0;
        check_outputs("reset_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pause_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid active_after: got %b expected 0", pause_active);
        end
        send_frame(c_mc_da, 48'h12_34_56_78_9A_BC, 16'h8808, 16'h0001, 16'd1, 64);
        exp_cnt = 16'd1; exp_quanta = 16'd1; exp_sa = 48'h12_34_56_78_9A_BC;
        measure_active(64, "reset_mid");
        check_outputs("reset_mid");
    endtask

    task automatic test_unicast();
        logic exp_acc;
`ifdef PAUSE_UNICAST_DA_EN
        exp_acc = 1'b1;
`else
        exp_acc = 1'b0;
`endif
        send_frame(c_station, 48'h55_AA_55_AA_55_AA, 16'h8808, 16'h0001, 16'd1, 64);
        @(negedge clk);
        checks++;
        if (pause_frame_strobe !== exp_acc || pause_active !== exp_acc) begin
            errors++;
            $display("FAIL unicast strobe/active: got %b/%b expected %b/%b",
                     pause_frame_strobe, pause_active, exp_acc, exp_acc);
        end
        if (exp_acc) begin
            exp_cnt = exp_cnt + 16'd1; exp_quanta = 16'd1; exp_sa = 48'h55_AA_55_AA_55_AA;
        end
        check_outputs("unicast");
        repeat (70) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reject();
        test_zero_clear();
        test_override();
        test_back_to_back();
        test_reset_mid();
        test_unicast();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_pause_detect.md
# rx_pause_detect

Receive-side MAC control block that parses frames leaving the MAC receive interface, recognises IEEE 802.3x PAUSE frames, and runs the pause timer that holds off the local transmitter. It is the far-end counterpart of the pause request generator that sits beside the receive FIFO. It lives in the MAC receive clock domain between the MAC byte interface and the transmit-side valid gating. When the link partner signals FIFO overflow, this block stops the bridge from sending.

## Interface
Parameters:
- QUANTUM_CYCLES, 64: clock cycles per pause quantum (512 bit times; 64 at 100 Mb/s with the MII byte clock).
- STATION_ADDR, 48'h02_00_00_00_00_01: local unicast MAC address. Used only with the configuration macro.

Ports:
- clk  in  1: MAC receive byte clock.
- reset  in  1: asynchronous, active-high reset.
- rx_mac_data  in  8: received byte, first byte is DA[47:40], FCS included.
- rx_mac_valid  in  1: high for every byte of one frame, contiguous; low between frames.
- pause_active  out  1: high while the pause timer is non-zero.
- pause_quanta  out  16: pause_time field of the last accepted PAUSE frame.
- pause_src_addr  out  48: SA of the last accepted PAUSE frame.
- pause_frame_strobe  out  1: one-cycle pulse per accepted PAUSE frame.
- pause_frame_cnt  out  16: accepted PAUSE frames; saturates at 16'hFFFF.

## Operation
- Byte index counter is 7 bits. It counts bytes of the current frame and saturates at 64.
- Parser FSM:
  - IDLE: waits for rx_mac_valid=1; byte 0 enters HDR.
  - HDR: compares bytes 0-17 on the fly.
    - DA (0-5) = 01-80-C2-00-00-01.
    - EtherType (12-13) = 88-08.
    - Opcode (14-15) = 00-01.
    - SA (6-11) and pause_time (16-17, MSB first) are captured into shadow registers.
    - Any mismatch goes to DROP.
    - After byte 17, goes to PAD.
  - PAD: counts remaining bytes; content is ignored.
  - DROP: ignores bytes until rx_mac_valid=0, then returns to IDLE.
- Frame end is the first cycle with rx_mac_valid=0 after a valid byte. The frame is accepted only if the FSM is in PAD and the byte count is at least 64 (runts are discarded). The FSM always returns to IDLE at frame end.
- On acceptance, in the next cycle:
  - pause_src_addr and pause_quanta load from the shadow registers.
  - pause_frame_strobe=1.
  - pause_frame_cnt increments.
  - The timer reloads: quanta_left = pause_time, sub_cnt = QUANTUM_CYCLES-1.
- Timer:
  - While quanta_left≠0: sub_cnt decrements every cycle. At sub_cnt=0 it reloads QUANTUM_CYCLES-1 and quanta_left decrements.
  - pause_active = (quanta_left≠0).
- pause_time=0 clears the timer; transmission resumes immediately.
- A new accepted frame while paused overrides the remaining time (it may lengthen or shorten it).
- Shadow registers of rejected frames never reach the outputs.

## Timing
- Reset values: all outputs 0, FSM IDLE, all counters 0.
- Reset is asynchronous at any point, including mid-frame or mid-pause. The next frame after release parses from byte 0.
- Let cycle E be the first rx_mac_valid=0 cycle after the frame.
  - pause_frame_strobe is high in cycle E+1 only.
  - pause_active is high for exactly pause_time×QUANTUM_CYCLES cycles, starting at E+1.
- Back-to-back frames with a single idle cycle are parsed without loss.
- Timer load at E+1 takes priority over the decrement in that same cycle.

## Configuration
- PAUSE_UNICAST_DA_EN defined: DA equal to STATION_ADDR is also accepted, in addition to the multicast 01-80-C2-00-00-01.
- PAUSE_UNICAST_DA_EN undefined: only the multicast DA is accepted. STATION_ADDR is unused.

## Test plan
- 64-byte PAUSE frame, pause_time=16'h0003, QUANTUM_CYCLES=64:
  - strobe is high at E+1 only;
  - pause_active is high for 192 cycles;
  - pause_quanta=3, pause_src_addr equals the sent SA, pause_frame_cnt=1.
- Same frame truncated to 60 bytes, or with EtherType 08-00, or with opcode 00-02: no strobe, pause_active stays 0, pause_frame_cnt unchanged.
- pause_time=100 frame, then a second frame with pause_time=0 arriving 1000 cycles later: pause_active drops at the second frame's E+1.
- Frame with pause_time=2, then one with pause_time=5 arriving 50 cycles later: pause_active stays high for 320 cycles from the second frame's E+1.
- reset asserted at byte 10 of a PAUSE frame, released, then a valid PAUSE frame with pause_time=1: the first frame has no effect; the second gives 64 active cycles.
- With PAUSE_UNICAST_DA_EN, a frame whose DA equals STATION_ADDR is accepted; without the macro the same frame is dropped.
